// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - MEM-stage instruction bundle from EX and registered MEM/WB results to WB
interface mem_stage_if;
   logic        in_mem_read;
   logic        in_mem_write;
   logic        in_byte;
   logic        in_unsigned;
   logic        in_mem_to_reg;
   logic        in_reg_write;
   logic [4:0]  in_write_back_destination;
   logic [31:0] in_alu_result;
   logic [31:0] in_write_data;
   logic        in_branch;
   logic        in_zero;
   logic [31:0] in_branch_target;
   logic        in_stall;
   logic        in_flush;

   logic        pc_src_out;
   logic [31:0] branch_target_out;
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic [4:0]  write_back_destination_out;
   logic [31:0] address_out;
   logic [31:0] read_data_out;

   modport master (
      output in_mem_read, in_mem_write, in_byte, in_unsigned,
      output in_mem_to_reg, in_reg_write, in_write_back_destination,
      output in_alu_result, in_write_data,
      output in_branch, in_zero, in_branch_target,
      output in_stall, in_flush,
      input  pc_src_out, branch_target_out,
      input  mem_to_reg_out, reg_write_out, write_back_destination_out,
      input  address_out, read_data_out
   );

   modport slave (
      input  in_mem_read, in_mem_write, in_byte, in_unsigned,
      input  in_mem_to_reg, in_reg_write, in_write_back_destination,
      input  in_alu_result, in_write_data,
      input  in_branch, in_zero, in_branch_target,
      input  in_stall, in_flush,
      output pc_src_out, branch_target_out,
      output mem_to_reg_out, reg_write_out, write_back_destination_out,
      output address_out, read_data_out
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage with 64-word data memory and MEM/WB register
module mem_stage #(
   parameter int MEM_WORDS = 64,
   parameter int ADDR_BITS = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_stage_if.slave bus
);

   logic [31:0]          mem [MEM_WORDS];
   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           lane;
   logic [31:0]          rd_word;
   logic [7:0]           rd_byte;
   logic [31:0]          load_data;
   logic                 store_en;
   logic [3:0]           byte_en;
   logic [31:0]          wr_data;
   logic [31:0]          wr_word;

   assign word_idx = bus.in_alu_result[ADDR_BITS+1:2];
   assign lane     = bus.in_alu_result[1:0];
   assign rd_word  = mem[word_idx];
   assign rd_byte  = rd_word[{lane, 3'b000} +: 8];

   always_comb begin
      load_data = '0;
      if (bus.in_mem_read) begin
         if (bus.in_byte)
            load_data = bus.in_unsigned ? {24'b0, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
         else
            load_data = rd_word;
      end
   end

   assign store_en = bus.in_mem_write & ~bus.in_stall & ~bus.in_flush;
   assign byte_en  = bus.in_byte ? (4'b0001 << lane) : 4'b1111;
   assign wr_data  = bus.in_byte ? {4{bus.in_write_data[7:0]}} : bus.in_write_data;

   // Read-modify-write merge so byte stores leave the other lanes untouched.
   always_comb begin
      wr_word = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (byte_en[b])
            wr_word[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_WORDS; i++)
            mem[i] <= '0;
      end else if (store_en) begin
         mem[word_idx] <= wr_word;
      end
   end

   // MEM/WB register: flush beats stall, stall holds everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_to_reg_out             <= 1'b0;
         bus.reg_write_out              <= 1'b0;
         bus.write_back_destination_out <= '0;
         bus.address_out                <= '0;
         bus.read_data_out              <= '0;
      end else if (bus.in_flush) begin
         bus.mem_to_reg_out             <= 1'b0;
         bus.reg_write_out              <= 1'b0;
         bus.write_back_destination_out <= '0;
         bus.address_out                <= '0;
         bus.read_data_out              <= '0;
      end else if (!bus.in_stall) begin
         bus.mem_to_reg_out             <= bus.in_mem_to_reg;
         bus.reg_write_out              <= bus.in_reg_write;
         bus.write_back_destination_out <= bus.in_write_back_destination;
         bus.address_out                <= bus.in_alu_result;
         bus.read_data_out              <= load_data;
      end
   end

   assign bus.pc_src_out        = bus.in_branch & bus.in_zero & ~bus.in_flush;
   assign bus.branch_target_out = bus.in_branch_target;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

   typedef struct {
      string       nm;
      int          due;
      int          kind;
      logic        m2r;
      logic        rw;
      logic [4:0]  dest;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        pc;
      logic [31:0] tgt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t last_exp;

   mem_stage_if bus();

   mem_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic idle_inputs();
      bus.in_mem_read = 0; bus.in_mem_write = 0; bus.in_byte = 0; bus.in_unsigned = 0;
      bus.in_mem_to_reg = 0; bus.in_reg_write = 0; bus.in_write_back_destination = 0;
      bus.in_alu_result = 0; bus.in_write_data = 0;
      bus.in_branch = 0; bus.in_zero = 0; bus.in_branch_target = 0;
      bus.in_stall = 0; bus.in_flush = 0;
   endtask

   task automatic op(input string nm, input logic mr, mw, byt, uns, m2r, rw,
                     input logic [4:0] dest, input logic [31:0] alu, wd,
                     input logic stall, flush, input logic [31:0] exp_rd);
      exp_t e;
      @(posedge clk); #1;
      idle_inputs();
      bus.in_mem_read = mr; bus.in_mem_write = mw; bus.in_byte = byt; bus.in_unsigned = uns;
      bus.in_mem_to_reg = m2r; bus.in_reg_write = rw; bus.in_write_back_destination = dest;
      bus.in_alu_result = alu; bus.in_write_data = wd;
      bus.in_stall = stall; bus.in_flush = flush;
      if (flush) begin
         e.kind = 1; e.m2r = 0; e.rw = 0;
         last_exp = e;
      end else if (stall) begin
         e = last_exp;
      end else begin
         e.kind = 0; e.m2r = m2r; e.rw = rw; e.dest = dest; e.addr = alu; e.rdata = exp_rd;
         last_exp = e;
      end
      e.nm = nm;
      e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic br(input string nm, input logic b, z, input logic [31:0] tgt,
                     input logic flush, input logic exp_pc);
      exp_t e;
      @(posedge clk); #1;
      idle_inputs();
      bus.in_branch = b; bus.in_zero = z; bus.in_branch_target = tgt; bus.in_flush = flush;
      e.nm = nm; e.kind = 2; e.due = cyc; e.pc = exp_pc; e.tgt = tgt;
      sb.push_back(e);
   endtask

   task automatic push_zero(input string nm);
      exp_t e;
      e.nm = nm; e.kind = 0; e.due = cyc;
      e.m2r = 0; e.rw = 0; e.dest = 0; e.addr = 0; e.rdata = 0;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.due < cyc) begin
            errors++;
            $display("FAIL %s: entry due cycle %0d not checked, now %0d", e.nm, e.due, cyc);
         end else if (e.kind == 0) begin
            if ({bus.mem_to_reg_out, bus.reg_write_out, bus.write_back_destination_out,
                 bus.address_out, bus.read_data_out} !== {e.m2r, e.rw, e.dest, e.addr, e.rdata}) begin
               errors++;
               $display("FAIL %s: got m2r=%b rw=%b dest=%0d addr=%h rdata=%h, expected m2r=%b rw=%b dest=%0d addr=%h rdata=%h",
                        e.nm, bus.mem_to_reg_out, bus.reg_write_out, bus.write_back_destination_out,
                        bus.address_out, bus.read_data_out, e.m2r, e.rw, e.dest, e.addr, e.rdata);
            end
         end else if (e.kind == 1) begin
            if ({bus.mem_to_reg_out, bus.reg_write_out} !== {e.m2r, e.rw}) begin
               errors++;
               $display("FAIL %s: got m2r=%b rw=%b, expected m2r=%b rw=%b",
                        e.nm, bus.mem_to_reg_out, bus.reg_write_out, e.m2r, e.rw);
            end
         end else begin
            if ({bus.pc_src_out, bus.branch_target_out} !== {e.pc, e.tgt}) begin
               errors++;
               $display("FAIL %s: got pc_src=%b target=%h, expected pc_src=%b target=%h",
                        e.nm, bus.pc_src_out, bus.branch_target_out, e.pc, e.tgt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         push_zero("reset_hold");
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      //   name          mr mw by un m2r rw dest  alu            wd             st fl exp_rd
      op("lw_after_rst", 1, 0, 0, 0, 0, 1, 5'd2, 32'h0000_0010, 32'h0,          0, 0, 32'h0000_0000);
      op("sw_deadbeef",  0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_0020, 32'hDEAD_BEEF,  0, 0, 32'h0000_0000);
      op("lb_0x23",      1, 0, 1, 0, 0, 1, 5'd4, 32'h0000_0023, 32'h0,          0, 0, 32'hFFFF_FFDE);
      op("lbu_0x21",     1, 0, 1, 1, 0, 1, 5'd5, 32'h0000_0021, 32'h0,          0, 0, 32'h0000_00BE);
      op("lw_0x20",      1, 0, 0, 0, 0, 1, 5'd6, 32'h0000_0020, 32'h0,          0, 0, 32'hDEAD_BEEF);
      op("sb_0x22",      0, 1, 1, 0, 0, 0, 5'd0, 32'h0000_0022, 32'hAAAA_AA55,  0, 0, 32'h0000_0000);
      op("lw_merge",     1, 0, 0, 0, 0, 1, 5'd7, 32'h0000_0020, 32'h0,          0, 0, 32'hDE55_BEEF);
      op("lw_alias120",  1, 0, 0, 0, 0, 1, 5'd8, 32'h0000_0120, 32'h0,          0, 0, 32'hDE55_BEEF);
      op("lb_pos_0x22",  1, 0, 1, 0, 0, 1, 5'd8, 32'h0000_0022, 32'h0,          0, 0, 32'h0000_0055);
      op("lbu_0x23",     1, 0, 1, 1, 0, 1, 5'd8, 32'h0000_0023, 32'h0,          0, 0, 32'h0000_00DE);
      op("lb_0x20",      1, 0, 1, 0, 0, 1, 5'd8, 32'h0000_0020, 32'h0,          0, 0, 32'hFFFF_FFEF);
      op("sw_alias1a4",  0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_01A4, 32'hCAFE_F00D,  0, 0, 32'h0000_0000);
      op("lw_0xa4",      1, 0, 0, 0, 0, 1, 5'd10, 32'h0000_00A4, 32'h0,         0, 0, 32'hCAFE_F00D);
      op("lbu_0xa5",     1, 0, 1, 1, 0, 1, 5'd10, 32'h0000_00A5, 32'h0,         0, 0, 32'h0000_00F0);
      op("ld_st_same",   1, 1, 0, 0, 0, 1, 5'd11, 32'h0000_0020, 32'h0102_0304, 0, 0, 32'hDE55_BEEF);
      op("lw_after_ls",  1, 0, 0, 0, 0, 1, 5'd11, 32'h0000_0020, 32'h0,         0, 0, 32'h0102_0304);
      op("lw_unaligned", 1, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0023, 32'h0,         0, 0, 32'h0102_0304);
      op("no_read_zero", 0, 0, 0, 0, 1, 1, 5'd7, 32'h0000_0020, 32'h0,          0, 0, 32'h0000_0000);
      op("sw_unaligned", 0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_004B, 32'h0F0E_0D0C,  0, 0, 32'h0000_0000);
      op("lw_0x48",      1, 0, 0, 0, 0, 1, 5'd13, 32'h0000_0048, 32'h0,         0, 0, 32'h0F0E_0D0C);

      op("lw_0x40_pre",  1, 0, 0, 0, 0, 1, 5'd3, 32'h0000_0040, 32'h0,          0, 0, 32'h0000_0000);
      for (int i = 0; i < 3; i++)
         op("sw_stalled",  0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_0040, 32'h1234_5678, 1, 0, 32'h0);
      op("lw_0x40_held", 1, 0, 0, 0, 0, 1, 5'd3, 32'h0000_0040, 32'h0,          0, 0, 32'h0000_0000);
      op("sw_0x40",      0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_0040, 32'h1234_5678,  0, 0, 32'h0000_0000);
      op("lw_0x40_post", 1, 0, 0, 0, 0, 1, 5'd3, 32'h0000_0040, 32'h0,          0, 0, 32'h1234_5678);

      op("sw_flushed",   0, 1, 0, 0, 1, 1, 5'd14, 32'h0000_0044, 32'hAAAA_5555, 0, 1, 32'h0);
      op("lw_0x44",      1, 0, 0, 0, 0, 1, 5'd14, 32'h0000_0044, 32'h0,         0, 0, 32'h0000_0000);
      op("flush_stall",  1, 1, 0, 0, 1, 1, 5'd15, 32'h0000_0040, 32'hBBBB_BBBB, 1, 1, 32'h0);
      op("lw_0x40_fs",   1, 0, 0, 0, 0, 1, 5'd15, 32'h0000_0040, 32'h0,         0, 0, 32'h1234_5678);

      br("br_taken",     1, 1, 32'h0040_0040, 0, 1);
      br("br_not_zero",  1, 0, 32'h0040_0040, 0, 0);
      br("br_flushed",   1, 1, 32'h0040_0040, 1, 0);
      br("no_branch",    0, 1, 32'h0040_0080, 0, 0);

      op("pass_through", 0, 0, 0, 0, 1, 1, 5'd9, 32'h0000_002A, 32'h0,          0, 0, 32'h0000_0000);
      op("pass_hold",    0, 0, 0, 0, 0, 0, 5'd1, 32'h0000_0099, 32'h0,          1, 0, 32'h0);

      // Asynchronous reset mid-cycle: the held values must vanish before the next edge.
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[$].due == cyc) void'(sb.pop_back());
      idle_inputs();
      rst_n = 1'b0;
      push_zero("async_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      op("lw_0x20_rst",  1, 0, 0, 0, 0, 1, 5'd2, 32'h0000_0020, 32'h0,          0, 0, 32'h0000_0000);
      op("lw_0x40_rst",  1, 0, 0, 0, 0, 1, 5'd2, 32'h0000_0040, 32'h0,          0, 0, 32'h0000_0000);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
